// File: rtl/sc_lane_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : sc_lane_scheduler_if
// Purpose  : Control and lane-select bundle between the game logic and the
//            background lane scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface sc_lane_scheduler_if #(
  parameter int LANES = 4,
  parameter int PW    = 4
);
  logic                  SC_LANESCHED_startButton_InLow;
  logic                  SC_LANESCHED_tick_InLow;
  logic                  SC_LANESCHED_pause_InHigh;
  logic [LANES*PW-1:0]   SC_LANESCHED_period_In;
  logic [LANES-1:0]      SC_LANESCHED_dir_In;
  logic                  SC_LANESCHED_clear_OutLow;
  logic [2*LANES-1:0]    SC_LANESCHED_shiftselection_Out;
  logic                  SC_LANESCHED_upcount_OutLow;
  logic                  SC_LANESCHED_overrun_Out;

  modport master (
    output SC_LANESCHED_startButton_InLow,
    output SC_LANESCHED_tick_InLow,
    output SC_LANESCHED_pause_InHigh,
    output SC_LANESCHED_period_In,
    output SC_LANESCHED_dir_In,
    input  SC_LANESCHED_clear_OutLow,
    input  SC_LANESCHED_shiftselection_Out,
    input  SC_LANESCHED_upcount_OutLow,
    input  SC_LANESCHED_overrun_Out
  );

  modport slave (
    input  SC_LANESCHED_startButton_InLow,
    input  SC_LANESCHED_tick_InLow,
    input  SC_LANESCHED_pause_InHigh,
    input  SC_LANESCHED_period_In,
    input  SC_LANESCHED_dir_In,
    output SC_LANESCHED_clear_OutLow,
    output SC_LANESCHED_shiftselection_Out,
    output SC_LANESCHED_upcount_OutLow,
    output SC_LANESCHED_overrun_Out
  );
endinterface
`default_nettype wire

// File: rtl/sc_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sc_lane_scheduler
// Purpose  : Tick-driven sequencer that shifts each background lane once per
//            its programmed period. Option macro: SC_LANESCHED_OVERRUN_EN
//            builds the sticky missed-tick flag.
// Revision : 1.0 - initial release
// ============================================================================
module sc_lane_scheduler #(
  parameter int LANES = 4,
  parameter int PW    = 4
) (
  input  logic               SC_STATEMACHINEBACKG_CLOCK_50,
  input  logic               SC_STATEMACHINEBACKG_RESET_InHigh,
  sc_lane_scheduler_if.slave bus
);

  localparam int                 c_IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(LANES - 1);

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_START = 3'd1,
    ST_INIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_IDLE  = 3'd4,
    ST_SCAN  = 3'd5,
    ST_COUNT = 3'd6
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [c_IDX_W-1:0]         r_idx;
  logic [c_IDX_W-1:0]         w_idx_nxt;
  logic                       r_pending;
  logic                       w_pending_nxt;
  logic [LANES-1:0][PW-1:0]   r_cnt;
  logic [LANES-1:0][PW-1:0]   w_load;
  logic [LANES-1:0]           w_hit;
  logic [LANES-1:0]           w_fire;
  logic [2*LANES-1:0]         w_sel;
  logic                       w_clear_n;
  logic                       w_upcount_n;
  logic                       w_tick;
  logic                       w_start_hi;
  logic                       w_in_idle;
  logic                       w_serve;

  assign w_tick     = ~bus.SC_LANESCHED_tick_InLow;
  assign w_start_hi = bus.SC_LANESCHED_startButton_InLow;
  assign w_in_idle  = (r_state == ST_IDLE);
  // A fresh tick or a latched one is served from IDLE unless paused.
  assign w_serve    = w_start_hi & ~bus.SC_LANESCHED_pause_InHigh & (w_tick | r_pending);

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign w_load[i] = (bus.SC_LANESCHED_period_In[i*PW +: PW] == '0)
                       ? PW'(1) : bus.SC_LANESCHED_period_In[i*PW +: PW];
      assign w_hit[i]  = (r_state == ST_SCAN) && (r_idx == c_IDX_W'(i));
      assign w_fire[i] = w_hit[i] && (r_cnt[i] == PW'(1));
    end
  endgenerate

  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      r_state   <= ST_RESET;
      r_idx     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      r_cnt <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (r_state == ST_INIT) begin
          r_cnt[k] <= w_load[k];
        end else if (w_hit[k]) begin
          r_cnt[k] <= w_fire[k] ? w_load[k] : (r_cnt[k] - PW'(1));
        end
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_pending_nxt = r_pending;
    w_clear_n     = 1'b1;
    w_upcount_n   = 1'b1;
    case (r_state)
      ST_RESET: begin
        w_clear_n   = 1'b0;
        w_state_nxt = ST_START;
      end
      ST_START: w_state_nxt = ST_IDLE;
      ST_INIT: begin
        w_clear_n   = 1'b0;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_start_hi) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!w_start_hi) begin
          w_state_nxt = ST_INIT;
        end else if (w_serve) begin
          w_state_nxt = ST_SCAN;
          w_idx_nxt   = '0;
        end
      end
      ST_SCAN: begin
        if (r_idx == c_LAST_IDX) begin
          w_state_nxt = ST_COUNT;
        end else begin
          w_idx_nxt = r_idx + c_IDX_W'(1);
        end
      end
      ST_COUNT: begin
        w_upcount_n = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Outside IDLE a tick is remembered; IDLE consumes or discards it.
    if (w_in_idle) begin
      if (!w_start_hi || w_serve) begin
        w_pending_nxt = 1'b0;
      end
    end else if (w_tick) begin
      w_pending_nxt = 1'b1;
    end
  end

  always_comb begin
    w_sel = {LANES{2'b11}};
    for (int k = 0; k < LANES; k++) begin
      if (w_fire[k]) begin
        w_sel[2*k +: 2] = bus.SC_LANESCHED_dir_In[k] ? 2'b01 : 2'b10;
      end
    end
  end

  assign bus.SC_LANESCHED_clear_OutLow       = w_clear_n;
  assign bus.SC_LANESCHED_upcount_OutLow     = w_upcount_n;
  assign bus.SC_LANESCHED_shiftselection_Out = w_sel;

`ifdef SC_LANESCHED_OVERRUN_EN
  logic r_overrun;
  logic w_drop;

  // Second tick while one is already waiting is lost.
  assign w_drop = w_tick & r_pending & (~w_in_idle | w_serve);

  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      r_overrun <= 1'b0;
    end else if (r_state == ST_INIT) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

  assign bus.SC_LANESCHED_overrun_Out = r_overrun;
`else
  assign bus.SC_LANESCHED_overrun_Out = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/sc_lane_scheduler.md
SC_LANE_SCHEDULER -- requirements
Module: sc_lane_scheduler

Interface
REQ-001 SHALL have parameter LANES, default 4, number of background lanes sequenced.
REQ-002 SHALL have parameter PW, default 4, width of each per-lane period field, in ticks.
REQ-003 SHALL have port SC_STATEMACHINEBACKG_CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port SC_STATEMACHINEBACKG_RESET_InHigh  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port SC_LANESCHED_startButton_InLow  in  1  game start request, active low.
REQ-006 SHALL have port SC_LANESCHED_tick_InLow  in  1  shared base-timer expiry, active low, one cycle wide.
REQ-007 SHALL have port SC_LANESCHED_pause_InHigh  in  1  freezes scheduling while high.
REQ-008 SHALL have port SC_LANESCHED_period_In  in  LANES*PW  per-lane period; lane i uses bits [i*PW +: PW].
REQ-009 SHALL have port SC_LANESCHED_dir_In  in  LANES  per-lane direction: 0 = left, 1 = right.
REQ-010 SHALL have port SC_LANESCHED_clear_OutLow  out  1  lane register clear, active low.
REQ-011 SHALL have port SC_LANESCHED_shiftselection_Out  out  2*LANES  per-lane code: 11 hold, 10 shift left, 01 shift right.
REQ-012 SHALL have port SC_LANESCHED_upcount_OutLow  out  1  base-timer restart pulse, active low.
REQ-013 SHALL have port SC_LANESCHED_overrun_Out  out  1  sticky missed-tick flag.

Function
REQ-014 SHALL implement the states RESET, START, INIT, HOLD, IDLE, SCAN and COUNT; all outputs SHALL be decoded combinationally from the state, the lane index and the lane counters.
REQ-015 SHALL sequence RESET -> START -> IDLE unconditionally, one cycle each.
REQ-016 IDLE SHALL go to INIT when start is low, else to SCAN with index 0 when a tick is pending and pause is low, else stay in IDLE.
REQ-017 INIT SHALL drive clear_OutLow=0 for exactly one cycle, load every lane counter with its period (0 is loaded as 1), clear overrun, and go to HOLD.
REQ-018 HOLD SHALL remain while start is low and go to IDLE when start is high.
REQ-019 SCAN SHALL visit one lane per cycle, in index order 0..LANES-1.
REQ-020 In SCAN, a lane counter equal to 1 SHALL produce that lane's shift code (dir 0 -> 10, dir 1 -> 01) and reload the counter with its period; otherwise the counter SHALL decrement.
REQ-021 At most one lane SHALL carry a non-11 shiftselection code in any cycle; all other lanes SHALL read 11.
REQ-022 After the last lane is scanned the FSM SHALL enter COUNT, drive upcount_OutLow=0 for one cycle, then return to IDLE.
REQ-023 Latency: a tick sampled in IDLE at cycle n SHALL produce SCAN lane i at cycle n+1+i, COUNT at n+LANES+1 and IDLE at n+LANES+2.
REQ-024 A lane with period P SHALL shift exactly once every P ticks, with the first shift on the P-th tick after INIT.
REQ-025 A tick arriving in any state other than IDLE SHALL set a pending flag, and that tick SHALL be served on the next IDLE cycle.
REQ-026 A tick arriving while a tick is already pending SHALL be dropped.
REQ-027 A start-low event SHALL outrank a pending tick, and a pending tick SHALL be discarded on entry to INIT.
REQ-028 While pause is high in IDLE, ticks SHALL be discarded (not latched); a SCAN or COUNT already in progress SHALL complete normally.
REQ-029 Period values SHALL be sampled only at INIT and at each reload; changes between these points SHALL have no effect until then.
REQ-030 Outside INIT, RESET, SCAN and COUNT, outputs SHALL be clear_OutLow=1, all shiftselection=11 and upcount_OutLow=1.
REQ-031 Any unused state encoding SHALL go to IDLE with these idle output values.

Reset
REQ-032 Asserting reset in any state SHALL immediately force RESET, zero all lane counters, clear the pending flag, clear overrun and reset the lane index to 0.
REQ-033 While in RESET, outputs SHALL be clear_OutLow=0, all shiftselection=11, upcount_OutLow=1 and overrun_Out=0.
REQ-034 Reset asserted mid-SCAN SHALL suppress the remaining shifts of that scan on the same cycle.

Configuration
REQ-035 With macro SC_LANESCHED_OVERRUN_EN defined, a tick dropped per REQ-026 SHALL set overrun_Out=1 until INIT or reset.
REQ-036 Without SC_LANESCHED_OVERRUN_EN, overrun_Out SHALL be tied to 0 and no overrun logic SHALL be built; all other behaviour SHALL be unchanged.

Verification
REQ-037 Reset, then start held low for 3 cycles -> clear_OutLow=0 in RESET and for exactly one INIT cycle; the FSM stays in HOLD until start goes high.
REQ-038 LANES=4, periods {1,2,3,4}, dirs {0,1,0,1}, 12 ticks -> lanes shift 12, 6, 4 and 3 times, with codes 10, 01, 10 and 01 respectively, never two lanes active in one cycle.
REQ-039 A single tick in IDLE at cycle n -> upcount_OutLow=0 at cycle n+5 and IDLE at cycle n+6.
REQ-040 Two ticks during one SCAN with SC_LANESCHED_OVERRUN_EN defined -> exactly one extra scan runs and overrun_Out=1; with the macro undefined, overrun_Out stays 0.
REQ-041 Pause high while 3 ticks arrive, then pause low -> no SCAN is entered and no counter changes.
REQ-042 Reset asserted during the scan of lane 2 -> RESET on the same cycle, lane 2 and lane 3 show no shift code, and all counters read 0.
